serial_bus_arbiter: RTL and testbench

//  Round-robin arbiter for the shared serial bus. Grants exclusive ownership to
//  one of NUM_MASTERS masters (each with master_in_port/out-port pair).

---
 rtl/serial_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// Round-robin owner arbiter for the shared serial bus; grant held until release or request drop.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN (revokes after TIMEOUT_CYCLES).
module serial_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ID_W           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] m_req,
    input  logic [NUM_MASTERS-1:0] m_rel,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [ID_W-1:0]        grant_id,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("serial_bus_arbiter: unsupported parameter values");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [ID_W-1:0]        grant_id_q;
    logic                   busy_q;
    logic [ID_W-1:0]        rr_q;

    logic                   any_req;
    logic [ID_W-1:0]        win_d;
    logic [ID_W-1:0]        scan_idx;
    logic                   owner_req;
    logic                   owner_rel;

    // Scan starts just after the last owner, so that owner is considered last.
    always_comb begin
        any_req  = 1'b0;
        win_d    = '0;
        scan_idx = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            scan_idx = ID_W'((32'(rr_q) + i) % NUM_MASTERS);
            if (!any_req && m_req[scan_idx]) begin
                any_req = 1'b1;
                win_d   = scan_idx;
            end
        end
    end

    assign owner_req = m_req[grant_id_q];
    assign owner_rel = m_rel[grant_id_q];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_q;
    logic             timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            rr_q       <= ID_W'(NUM_MASTERS - 1);
            wd_q       <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE, TURN: begin
                    if (any_req) begin
                        state_q    <= BUSY;
                        grant_q    <= NUM_MASTERS'(1) << win_d;
                        grant_id_q <= win_d;
                        rr_q       <= win_d;
                        busy_q     <= 1'b1;
                        wd_q       <= '0;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    // A genuine release wins over a coincident watchdog expiry.
                    if (owner_rel || !owner_req) begin
                        state_q <= TURN;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= TURN;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= '0;
                    grant_id_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign timeout_err = timeout_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            rr_q       <= ID_W'(NUM_MASTERS - 1);
        end else begin
            case (state_q)
                IDLE, TURN: begin
                    if (any_req) begin
                        state_q    <= BUSY;
                        grant_q    <= NUM_MASTERS'(1) << win_d;
                        grant_id_q <= win_d;
                        rr_q       <= win_d;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (owner_rel || !owner_req) begin
                        state_q <= TURN;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= '0;
                    grant_id_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign timeout_err = 1'b0;
`endif

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign bus_busy = busy_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Scoreboard bench for serial_bus_arbiter (2 masters): stimulus queues per-cycle
// expectations, a posedge monitor pops and compares them.
module tb_serial_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] m_req;
    logic [1:0] m_rel;
    logic [1:0] grant;
    logic [0:0] grant_id;
    logic       bus_busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    serial_bus_arbiter #(
        .NUM_MASTERS   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_req      (m_req),
        .m_rel      (m_rel),
        .grant      (grant),
        .grant_id   (grant_id),
        .bus_busy   (bus_busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got grant=%b id=%b busy=%b to=%b, expected grant=%b id=%b busy=%b to=%b",
                     name, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endfunction

    // Monitor: outputs after each posedge are compared with whatever was queued for that cycle.
    always @(posedge clk) begin
        cyc++;
        #1;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            check(mon_e.name, {grant, grant_id, bus_busy, timeout_err}, mon_e.exp);
        end
    end

    task automatic step(input logic [1:0] req, input logic [1:0] rel,
                        input logic [1:0] g, input logic id, input logic busy,
                        input logic to, input string name);
        exp_t e;
        @(negedge clk);
        m_req = req;
        m_rel = rel;
        e.cyc  = cyc + 1;
        e.exp  = {g, id, busy, to};
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        m_req = 2'b00;
        m_rel = 2'b00;
        rst_n = 1'b0;
        #1;
        check("async_reset", {grant, grant_id, bus_busy, timeout_err}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        m_req = 2'b00;
        m_rel = 2'b00;
        do_reset();

        // Single requester: one-cycle latency, hold, drop, idle
        step(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "t1_grant");
        step(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "t1_hold");
        step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "t1_drop");
        step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "t1_idle");

        // Owner 0 drops request without release, master 1 granted after turnaround
        do_reset();
        step(2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "t4_grant0");
        step(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "t4_drop");
        step(2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "t4_rearb");

        // Non-owner release ignored; owner release; lone requester re-granted
        step(2'b10, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, "t3_nonowner_rel");
        step(2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "t3_hold");
        step(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, "t3_release");
        step(2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "t3_regrant_alone");
        step(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, "t3_drop");
        step(2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "rel_in_turn");
        step(2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "rel_in_idle");

        // Both request: master 0 first, release passes to master 1 after a gap
        do_reset();
        step(2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "t2_grant0");
        step(2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, "t2_gap");
        step(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "t2_rr");
        step(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "t2_hold");

        // Reset while master 1 owns the bus; first grant afterwards must go to master 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            logic [1:0] g;
            logic       w;
            w = 1'(k % 2);
            g = w ? 2'b10 : 2'b01;
            step(2'b11, 2'b00, g, w, 1'b1, 1'b0, "rr_grant");
            repeat (6) step(2'b11, 2'b00, g, w, 1'b1, 1'b0, "rr_hold");
            step(2'b11, g, 2'b00, w, 1'b0, 1'b0, "rr_gap");
        end

        do_reset();
`ifdef ARB_TIMEOUT_EN
        step(2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "wd_grant");
        repeat (15) step(2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "wd_hold");
        step(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, "wd_revoke");
        step(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "wd_next_owner");
        step(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, "wd_next_drop");
`else
        step(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "nowd_grant");
        repeat (100) step(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "nowd_hold");
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
